ula_seq: RTL and testbench
==========================

// Module: ula_seq
// PURPOSE
//  Registered, parametrised-width ALU for the SAP-1 datapath and successor to the combinational one-hot ULA.
//  - Encoded 3-bit opcode instead of one-hot op strobes.
//  - Registered result and status flags (N, Z, C, V).
//  - start/busy/done handshake.
//  - Multi-cycle shift-add multiply.
//  Sits between the A/B registers and the W-bus; eu gates the result onto the bus.
// PARAMETERS
//  WIDTH   8   datapath width in bits (>= 2)
// PORTS
//  clk      in   1      system clock, rising edge
//  rst_n    in   1      asynchronous, active-low reset
//  start    in   1      begin operation; sampled only when busy=0
//  op       in   3      opcode (ula_pkg)
//  a        in   WIDTH  operand A
//  b        in   WIDTH  operand B
//  eu       in   1      bus enable: bus_out = eu ? result : 0 (combinational)
//  busy     out  1      multiply in progress
//  done     out  1      one-cycle pulse when result/flags are updated
//  result   out  WIDTH  registered result
//  flags    out  4      registered {N,Z,C,V}
//  bus_out  out  WIDTH  gated result toward the W-bus
// BEHAVIOUR
//  - Reset (async, rst_n=0): busy=0, done=0, result=0, flags=0, FSM=IDLE, multiplier state cleared.
//    Reset mid-multiply aborts it. No partial result is kept.
//  - Opcodes:
//      000 ADD   A+B
//      001 SUB   A-B
//      010 AND
//      011 OR
//      100 XOR
//      101 NOT   ~A
//      110 MUL   low WIDTH bits of A*B
//      111 CMP   flags of A-B; result unchanged
//  - Single-cycle ops (all except MUL): start=1 at edge E0 (busy=0) updates result/flags at E0.
//    done=1 for the cycle after E0. Latency 1. Back-to-back starts allowed every cycle.
//  - MUL: at E0 capture a, b; busy=1; step counter=WIDTH.
//    One shift-add step per edge. The final step is at edge E0+WIDTH: result/flags updated, busy=0, done=1 for one cycle.
//    Next start is accepted at edge E0+WIDTH+1 or later.
//  - start while busy=1 is ignored (no queueing). a, b and op changes while busy are ignored.
//  - FSM: IDLE -(start & op==MUL)-> MUL; MUL -(count==1)-> IDLE. Single-cycle ops stay in IDLE.
//  - Flags:
//    - Z = (new result == 0); for CMP, Z is taken on the A-B difference.
//    - N = msb of the same value.
//    - ADD: C = carry out; V = signed overflow.
//    - SUB/CMP: C = 1 when there is no borrow (A >= B unsigned); V = signed overflow.
//    - AND/OR/XOR/NOT: C=0, V=0.
//    - MUL: C = V = (upper WIDTH bits of the 2*WIDTH product != 0).
//  - Arithmetic wraps modulo 2^WIDTH. All operands are unsigned except for the V computation.
//  - flags and result hold their values until the next completed operation.
//  - done never asserts without a preceding accepted start.
//  - eu does not affect computation or the handshake. bus_out follows result combinationally.
// STRUCTURE
//  - ula_pkg: opcode localparams (OP_ADD..OP_CMP), flag bit indices (FLG_N=3, FLG_Z=2, FLG_C=1, FLG_V=0).
//  - Sub-module ula_mul_seq (WIDTH):
//    - Shift-add multiplier with start/busy/done.
//    - Returns the 2*WIDTH product.
//    - Owns the step counter, $clog2(WIDTH+1) bits.
//  - Top level: opcode decode, single-cycle datapath, flag logic, output registers, bus gating.
// TESTING (WIDTH=8)
//  1. ADD a=0x0F, b=0xF0, start 1 cycle
//     -> result=0xFF, flags N=1 Z=0 C=0 V=0; done pulses 1 cycle after start.
//  2. ADD 0xFF+0x01 -> 0x00, Z=1 C=1 V=0.
//     SUB 0x0F-0xF0 -> 0x1F, C=0 V=0.
//     SUB 0x80-0x01 -> 0x7F, C=1 V=1.
//  3. MUL 0x0F*0x11 -> 0xFF, C=V=0; busy high 8 cycles, done at the 8th edge.
//     MUL 0x10*0x10 -> 0x00, Z=1 C=1 V=1.
//  4. During MUL, pulse start with ADD -> ignored, MUL result still correct.
//     Then CMP 0x05,0x05 -> result unchanged, Z=1 C=1 N=0 V=0.
//  5. Drop rst_n after 3 MUL cycles -> busy, done, result, flags = 0 immediately.
//     After release, ADD 0x01+0x02 -> 0x03.
//  6. NOT a=0x0F -> result=0xF0; eu=0 -> bus_out=0x00; eu=1 -> bus_out=0xF0 in the same cycle.

Source files
------------

// File: rtl/ula_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ula_pkg
//  Brief    : Opcode encodings, flag bit positions and FSM states for ula_seq
//  Revision : 1.0
// ============================================================================
package ula_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ula_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module   : ula_mul_seq
//  Brief    : Shift-add multiplier, one partial product per clock, 2*WIDTH product
//  Revision : 1.0
// ============================================================================
module ula_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;

  logic [2*WIDTH-1:0] w_addend;
  logic [2*WIDTH-1:0] w_acc_nxt;

  assign w_addend  = r_mplier[0] ? r_mcand : '0;
  assign w_acc_nxt = r_acc + w_addend;

  // done flags the edge on which the final step lands; product is the
  // post-step accumulator so the caller can register it on that same edge.
  assign busy    = r_busy;
  assign done    = r_busy && (r_cnt == CW'(1));
  assign product = w_acc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (start && !r_busy) begin
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_mplier <= b;
      r_cnt    <= CW'(WIDTH);
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CW'(1);
      if (done) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ula_seq.sv
`default_nettype none
// ============================================================================
//  Module   : ula_seq
//  Brief    : Registered SAP-1 ALU with N/Z/C/V flags, start/busy/done and
//             multi-cycle multiply; result gated onto the W-bus by eu
//  Revision : 1.0
// ============================================================================
module ula_seq
  import ula_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             eu,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic [WIDTH-1:0] bus_out
);

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0]   r_result;
  logic [3:0]         r_flags;
  logic               r_done;

  logic               w_accept;
  logic               w_mul_start;
  logic               w_mul_busy;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_prod;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic               w_upd;
  logic               w_wr_res;
  logic [WIDTH-1:0]   w_val;
  logic               w_c;
  logic               w_v;
  logic [3:0]         w_flg;

  assign w_accept    = start && (r_state == ST_IDLE);
  assign w_mul_start = w_accept && (op == OP_MUL);

  ula_mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (w_mul_start),
    .a       (a),
    .b       (b),
    .busy    (w_mul_busy),
    .done    (w_mul_done),
    .product (w_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_mul_start) w_state_nxt = ST_MUL;
      ST_MUL:  if (w_mul_done)  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    w_upd    = 1'b0;
    w_wr_res = 1'b0;
    w_val    = r_result;
    w_c      = 1'b0;
    w_v      = 1'b0;
    if (w_accept && (op != OP_MUL)) begin
      w_upd    = 1'b1;
      w_wr_res = 1'b1;
      case (op)
        OP_ADD: begin
          w_val = w_sum[WIDTH-1:0];
          w_c   = w_sum[WIDTH];
          w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
        end
        OP_SUB, OP_CMP: begin
          // CMP shares the subtractor but leaves the result register alone
          w_wr_res = (op == OP_SUB);
          w_val    = w_diff[WIDTH-1:0];
          w_c      = ~w_diff[WIDTH];
          w_v      = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
        end
        OP_AND:  w_val = a & b;
        OP_OR:   w_val = a | b;
        OP_XOR:  w_val = a ^ b;
        OP_NOT:  w_val = ~a;
        default: w_val = r_result;
      endcase
    end else if (w_mul_done) begin
      w_upd    = 1'b1;
      w_wr_res = 1'b1;
      w_val    = w_prod[WIDTH-1:0];
      w_c      = |w_prod[2*WIDTH-1:WIDTH];
      w_v      = |w_prod[2*WIDTH-1:WIDTH];
    end
  end

  always_comb begin
    w_flg        = 4'b0000;
    w_flg[FLG_N] = w_val[WIDTH-1];
    w_flg[FLG_Z] = (w_val == '0);
    w_flg[FLG_C] = w_c;
    w_flg[FLG_V] = w_v;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_flags  <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_upd;
      if (w_upd) begin
        r_flags <= w_flg;
        if (w_wr_res) begin
          r_result <= w_val;
        end
      end
    end
  end

  assign busy    = w_mul_busy;
  assign done    = r_done;
  assign result  = r_result;
  assign flags   = r_flags;
  assign bus_out = eu ? r_result : '0;

endmodule
`default_nettype wire

// File: tb/tb_ula_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ula_seq
//  Brief    : Directed self-checking bench for ula_seq (WIDTH=8)
//  Revision : 1.0
// ============================================================================
module tb_ula_seq;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             eu;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic [WIDTH-1:0] bus_out;

  int n_checks = 0;
  int n_pass   = 0;

  ula_seq #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .eu      (eu),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .flags   (flags),
    .bus_out (bus_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // flags are {N,Z,C,V}; single-cycle op, sampled 1 ns after the accepting edge
  task automatic single(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic mul_start(input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    start = 1'b1; op = 3'b110; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 3'b000; a = '0; b = '0; eu = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",   busy,   0);
    chk("rst_done",   done,   0);
    chk("rst_result", result, 0);
    chk("rst_flags",  flags,  0);
    @(negedge clk) rst_n = 1'b1;

    // 1: ADD 0x0F+0xF0
    single(3'b000, 8'h0F, 8'hF0);
    chk("add1_result", result, 8'hFF);
    chk("add1_flags",  flags,  4'b1000);
    chk("add1_done",   done,   1);
    @(posedge clk); #1;
    chk("add1_done_low", done, 0);

    // 2: carry, borrow and overflow cases
    single(3'b000, 8'hFF, 8'h01);
    chk("add2_result", result, 8'h00);
    chk("add2_flags",  flags,  4'b0110);
    single(3'b001, 8'h0F, 8'hF0);
    chk("sub1_result", result, 8'h1F);
    chk("sub1_flags",  flags,  4'b0000);
    single(3'b001, 8'h80, 8'h01);
    chk("sub2_result", result, 8'h7F);
    chk("sub2_flags",  flags,  4'b0011);
    chk("b2b_done",    done,   1);

    // 3: MUL 0x0F*0x11, busy for 8 cycles, done at 8th edge
    mul_start(8'h0F, 8'h11);
    chk("mul1_busy_e0", busy, 1);
    chk("mul1_done_e0", done, 0);
    for (int i = 1; i < 8; i++) begin
      @(posedge clk); #1;
      chk($sformatf("mul1_busy_e%0d", i), busy, 1);
      chk($sformatf("mul1_done_e%0d", i), done, 0);
    end
    @(posedge clk); #1;
    chk("mul1_busy_e8", busy,   0);
    chk("mul1_done_e8", done,   1);
    chk("mul1_result",  result, 8'hFF);
    chk("mul1_flags",   flags,  4'b1000);
    @(posedge clk); #1;
    chk("mul1_done_e9", done, 0);

    mul_start(8'h10, 8'h10);
    repeat (8) @(posedge clk);
    #1;
    chk("mul2_result", result, 8'h00);
    chk("mul2_flags",  flags,  4'b0111);

    // 4: ADD pulsed mid-multiply must be ignored
    mul_start(8'h03, 8'h05);
    @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 3'b000; a = 8'h01; b = 8'h02;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mul3_busy_e7", busy, 1);
    @(posedge clk); #1;
    chk("mul3_result", result, 8'h0F);
    chk("mul3_flags",  flags,  4'b0000);
    @(posedge clk); #1;
    chk("mul3_no_extra_done", done, 0);
    chk("mul3_result_hold",   result, 8'h0F);
    single(3'b111, 8'h05, 8'h05);
    chk("cmp_result", result, 8'h0F);
    chk("cmp_flags",  flags,  4'b0110);

    // 5: async reset three cycles into a multiply
    mul_start(8'h0F, 8'h11);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy",   busy,   0);
    chk("arst_done",   done,   0);
    chk("arst_result", result, 0);
    chk("arst_flags",  flags,  0);
    @(negedge clk) rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("arst_no_done", done,   0);
    chk("arst_no_res",  result, 0);
    single(3'b000, 8'h01, 8'h02);
    chk("post_rst_add", result, 8'h03);

    // 6: NOT plus bus gating
    single(3'b101, 8'h0F, 8'h00);
    chk("not_result", result, 8'hF0);
    chk("not_flags",  flags,  4'b1000);
    eu = 1'b0; #1;
    chk("bus_eu0", bus_out, 8'h00);
    eu = 1'b1; #1;
    chk("bus_eu1", bus_out, 8'hF0);
    single(3'b010, 8'hCC, 8'hAA);
    chk("and_bus",  bus_out, 8'h88);
    single(3'b100, 8'hCC, 8'hAA);
    chk("xor_result", result, 8'h66);
    single(3'b011, 8'h00, 8'h00);
    chk("or_flags", flags, 4'b0100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
